// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter: state encoding, default
// timing/geometry parameters and block/counter widths.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_I_FILL  = 2'd1,
        ST_D_FILL  = 2'd2,
        ST_D_WRITE = 2'd3
    } state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } owner_t;

    localparam int DEF_MEM_LATENCY     = 4;
    localparam int DEF_WORDS_PER_BLOCK = 8;
    localparam int BLOCK_OFFSET_W      = 4;   // byte offset inside a 16-byte block
    localparam int CNT_W               = 4;
    localparam int ADDR_W              = 16;
    localparam int DATA_W              = 16;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side signals of the arbiter; slave is the arbiter's
// view, master is the view of whatever drives the caches and the memory.
interface mem_arbiter_if;
    import mem_arb_pkg::*;

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_data_valid;

    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              i_grant;
    logic              d_grant;
    logic              i_data_valid;
    logic              d_data_valid;
    logic [DATA_W-1:0] rdata;
    logic              i_done;
    logic              d_done;
    logic              busy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_data_valid,
        output mem_en, mem_wr, mem_addr, mem_wdata, i_grant, d_grant,
               i_data_valid, d_data_valid, rdata, i_done, d_done, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_data_valid,
        input  mem_en, mem_wr, mem_addr, mem_wdata, i_grant, d_grant,
               i_data_valid, d_data_valid, rdata, i_done, d_done, busy
    );

endinterface

// File: rtl/block_word_counter.sv
// Word counter for one cache block: synchronous clear, count enable and a
// flag raised when the count equals TERMINAL.
module block_word_counter
    import mem_arb_pkg::*;
#(
    parameter int TERMINAL = DEF_WORDS_PER_BLOCK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             terminal
);

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = (count == CNT_W'(TERMINAL));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache block fills, D-cache block fills and D-cache single-word
// writes onto one memory port, one transaction at a time, alternating on ties.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY     = DEF_MEM_LATENCY,
    parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);

    localparam int WORD_IDX_W = BLOCK_OFFSET_W - 1;

    if (MEM_LATENCY < 1 || 2 * WORDS_PER_BLOCK != 2 ** BLOCK_OFFSET_W) begin : g_param_check
        $error("mem_arbiter: block geometry or latency parameter out of range");
    end

    state_t                     state, state_nxt;
    owner_t                     last_grant;
    logic [ADDR_W-BLOCK_OFFSET_W-1:0] base;
    logic [ADDR_W-1:0]          wr_addr;
    logic [DATA_W-1:0]          wr_data;
    logic [CNT_W-1:0]           issue_cnt, ret_cnt;
    logic                       issue_end, ret_last;
    logic                       in_fill, issue_en, ret_en, fill_done;
    logic                       any_req, pick_d;
    logic                       unused_bits;

    assign in_fill   = (state == ST_I_FILL) || (state == ST_D_FILL);
    assign issue_en  = in_fill && !issue_end;
    assign ret_en    = in_fill && bus.mem_data_valid;
    assign fill_done = ret_en && ret_last;
    assign any_req   = bus.i_req || bus.d_req;
    // On a tie the side not granted last wins.
    assign pick_d    = (bus.i_req && bus.d_req) ? (last_grant == GRANT_I) : bus.d_req;

    block_word_counter #(.TERMINAL(WORDS_PER_BLOCK)) u_issue_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (state == ST_IDLE),
        .en       (issue_en),
        .count    (issue_cnt),
        .terminal (issue_end)
    );

    block_word_counter #(.TERMINAL(WORDS_PER_BLOCK - 1)) u_ret_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (state == ST_IDLE),
        .en       (ret_en),
        .count    (ret_cnt),
        .terminal (ret_last)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            last_grant <= GRANT_I;
            base       <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && any_req) begin
                last_grant <= pick_d ? GRANT_D : GRANT_I;
                base       <= pick_d ? bus.d_addr[ADDR_W-1:BLOCK_OFFSET_W]
                                     : bus.i_addr[ADDR_W-1:BLOCK_OFFSET_W];
                if (pick_d) begin
                    wr_addr <= bus.d_addr;
                    wr_data <= bus.d_wdata;
                end
            end
        end
    end

    // NOTE: next state is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    if (!pick_d)        state_nxt = ST_I_FILL;
                    else if (bus.d_we)  state_nxt = ST_D_WRITE;
                    else                state_nxt = ST_D_FILL;
                end
            end
            ST_I_FILL, ST_D_FILL: if (fill_done) state_nxt = ST_IDLE;
            ST_D_WRITE:           state_nxt = ST_IDLE;
            default:              state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.mem_en       = 1'b0;
        bus.mem_wr       = 1'b0;
        bus.mem_addr     = '0;
        bus.mem_wdata    = '0;
        bus.i_grant      = (state == ST_I_FILL);
        bus.d_grant      = (state == ST_D_FILL) || (state == ST_D_WRITE);
        bus.i_data_valid = bus.mem_data_valid && (state == ST_I_FILL);
        bus.d_data_valid = bus.mem_data_valid && (state == ST_D_FILL);
        bus.rdata        = bus.mem_rdata;
        bus.i_done       = fill_done && (state == ST_I_FILL);
        bus.d_done       = (fill_done && (state == ST_D_FILL)) || (state == ST_D_WRITE);
        bus.busy         = (state != ST_IDLE);
        if (issue_en) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = {base, issue_cnt[WORD_IDX_W-1:0], 1'b0};
        end else if (state == ST_D_WRITE) begin
            bus.mem_en    = 1'b1;
            bus.mem_wr    = 1'b1;
            bus.mem_addr  = wr_addr;
            bus.mem_wdata = wr_data;
        end
    end

    assign unused_bits = ^{bus.i_addr[BLOCK_OFFSET_W-1:0],
                           issue_cnt[CNT_W-1:WORD_IDX_W], ret_cnt};

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 4, cycles from memory read issue to mem_data_valid.
REQ-002 SHALL have parameter WORDS_PER_BLOCK, default 8, 16-bit words per cache block (16-byte block).
REQ-003 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: rst  in  1  reset, synchronous and active-low.
REQ-005 SHALL have ports: i_req in 1 I-cache fill request; i_addr in 16 I-cache miss address.
REQ-006 SHALL have ports: d_req in 1 D-cache request; d_we in 1 D-cache write (1) / fill (0); d_addr in 16 D-cache address; d_wdata in 16 D-cache write data.
REQ-007 SHALL have ports: mem_rdata in 16 memory read data; mem_data_valid in 1 memory read data valid.
REQ-008 SHALL have ports: mem_en out 1 memory access enable; mem_wr out 1 memory write; mem_addr out 16 memory address; mem_wdata out 16 memory write data.
REQ-009 SHALL have ports: i_grant out 1, d_grant out 1, I/D owns memory.
REQ-010 SHALL have ports: i_data_valid out 1, d_data_valid out 1, fill word valid for owner; rdata out 16 forwarded mem_rdata.
REQ-011 SHALL have ports: i_done out 1, d_done out 1, one-cycle transaction-complete pulse; busy out 1, state != IDLE.

Function
REQ-012 SHALL implement states IDLE, I_FILL, D_FILL, D_WRITE; one transaction in flight at a time.
REQ-013 In IDLE, at a rising edge with exactly one request asserted, SHALL enter I_FILL (i_req), D_FILL (d_req & ~d_we) or D_WRITE (d_req & d_we).
REQ-014 With i_req and d_req both asserted in IDLE, SHALL grant the requester not granted last; last_grant resets to I, so D wins the first tie.
REQ-015 On entry to a fill state, SHALL latch base = owner address[15:4] and clear issue and return counters.
REQ-016 Grant outputs SHALL be registered state decodes; held for the whole transaction.
REQ-017 In fill states SHALL assert mem_en=1, mem_wr=0, mem_addr={base,issue_cnt,1'b0} each cycle while issue_cnt < WORDS_PER_BLOCK; issue_cnt +1 per cycle; first issue in the first grant cycle.
REQ-018 Return counter SHALL increment on mem_data_valid only in a fill state; x_data_valid = mem_data_valid & (state==x fill); rdata = mem_rdata combinationally.
REQ-019 On the WORDS_PER_BLOCK-th valid return, SHALL pulse x_done the same cycle and return to IDLE next edge; a full fill occupies WORDS_PER_BLOCK+MEM_LATENCY-1 cycles (11 at defaults).
REQ-020 D_WRITE SHALL last exactly one cycle: mem_en=1, mem_wr=1, mem_addr=d_addr latched at grant, mem_wdata=d_wdata latched at grant, d_done=1; then IDLE.
REQ-021 Requests are sampled only in IDLE; deasserting req mid-transaction SHALL NOT abort it.
REQ-022 mem_data_valid in IDLE or D_WRITE SHALL be ignored (no valid/done output).
REQ-023 Back-to-back: new grant SHALL occur no earlier than one IDLE cycle after done; IDLE always lasts at least one cycle.
REQ-024 Outside active issue, mem_en=0, mem_wr=0, mem_addr=0, mem_wdata=0.

Reset
REQ-025 rst low at a rising edge SHALL force IDLE, last_grant=I, counters/base/latched data = 0, all outputs 0, including mid-transaction (abort, no done pulse).
REQ-026 Responses to issues made before reset SHALL be ignored after reset (falls under REQ-022).

Structure
REQ-027 Shared package mem_arb_pkg SHALL hold the state encoding, MEM_LATENCY and WORDS_PER_BLOCK defaults, and block-offset width constant.
REQ-028 Issue and return counters SHALL reuse one sub-module, block_word_counter (4-bit, enable, sync clear, terminal flag).

Verification
REQ-029 i_req, i_addr=0x1236 alone -> i_grant next cycle; mem_addr 0x1230,0x1232..0x123E on 8 consecutive cycles; 8 i_data_valid; i_done on 8th; IDLE after 11 busy cycles.
REQ-030 i_req & d_req same edge after reset -> D_FILL first; after d_done and 1 IDLE cycle, I_FILL granted.
REQ-031 d_req, d_we=1, d_addr=0x00A4, d_wdata=0xBEEF -> one cycle mem_en=1, mem_wr=1, mem_addr=0x00A4, mem_wdata=0xBEEF, d_done=1; busy low next cycle.
REQ-032 rst low during 5th issue of a D fill -> all outputs 0 next cycle; late mem_data_valid pulses produce no d_data_valid or d_done.
REQ-033 i_req dropped after grant, stray mem_data_valid in IDLE -> fill still completes with i_done; stray valid ignored.
